permutation_sequencer: RTL and testbench
========================================

// Module: permutation_sequencer
// PURPOSE
//  Iterative ASCON permutation controller; drives the round interface of the round function (pc/ps/pl chain).
//  - Registers the 320-bit state, produces round_o and feeds rnd_state_o to the combinational round function.
//  - Writes rnd_state_i back once per clock.
//  - Runs p^a (NB_ROUNDS_A rounds) or p^b (NB_ROUNDS_B rounds); returns the result with a valid/ready handshake.
// PARAMETERS
//  NB_ROUNDS_A  12  rounds for mode_i=0; legal 1..12; first round index = 12-NB_ROUNDS_A
//  NB_ROUNDS_B  6   rounds for mode_i=1; legal 1..12; first round index = 12-NB_ROUNDS_B
// PORTS
//  clock_i      in   1    clock, all state updates on rising edge
//  reset_i      in   1    synchronous reset, active high
//  start_i      in   1    permutation request; accepted when start_i & ready_o
//  mode_i       in   1    0: p^a, 1: p^b; sampled on accept only
//  state_i      in   320  type_state; input state, sampled on accept only
//  ready_o      out  1    block can accept a request
//  round_o      out  4    round index to round function (0..11)
//  rnd_state_o  out  320  type_state; current state register to round function
//  rnd_state_i  in   320  type_state; round function output (combinational from rnd_state_o, round_o)
//  done_o       out  1    single-cycle pulse: state_o holds the final result
//  state_o      out  320  type_state; equals state register; result valid while done_o=1 and in IDLE after done
//  abort_i      in   1    only when PERM_ABORT_EN is defined
// BEHAVIOUR
//  - Reset (reset_i=1 at an edge): FSM=IDLE, state_reg=0, round_cnt=0. Outputs: ready_o=1, done_o=0, round_o=0, state_o=rnd_state_o=0.
//  - Reset has priority over every other input, including mid-RUN; the run in progress is dropped, no done_o.
//  - FSM states IDLE, RUN, DONE:
//    - IDLE: ready_o=1, round_o=0. start_i=1 -> state_reg<=state_i; round_cnt<=12-N (N from mode_i); go to RUN.
//    - RUN: ready_o=0, round_o=round_cnt. Every edge: state_reg<=rnd_state_i.
//      - round_cnt<11: round_cnt++.
//      - round_cnt==11: round_cnt<=0; go to DONE.
//    - DONE: one cycle; done_o=1, ready_o=1, round_o=0.
//      - start_i=1 -> load as in IDLE; go to RUN (back-to-back, no bubble).
//      - Otherwise go to IDLE; state_reg is held.
//  - Latency: done_o is high exactly N+1 cycles after the accept edge (13 for p^12, 7 for p^6).
//  - start_i while ready_o=0 is ignored; it is not queued.
//  - mode_i and state_i are don't-care outside accept cycles.
//  - round_cnt is 4 bits, never exceeds 11, never wraps.
//  - The block does no arithmetic on the state; all transformation happens in the external round function.
// CONFIGURATION
//  PERM_ABORT_EN defined:
//   - Adds abort_i.
//   - abort_i=1 in RUN -> next edge FSM=IDLE, round_cnt=0, state_reg keeps its last value, done_o not asserted.
//   - abort_i is ignored in IDLE and DONE.
//   - If abort_i is high on the round_cnt==11 edge, abort wins; no done_o.
//  PERM_ABORT_EN undefined: no abort_i port; every accepted run completes unless reset.
// TESTING
//  1. Identity model (rnd_state_i=rnd_state_o); mode 0; state_i words = 64'h1..64'h5.
//     -> round_o = 0,1,..,11 on consecutive cycles; done_o 13 cycles after accept; state_o = input.
//  2. pc model (word2 ^= round_constant[round_o]); mode 0; zero state.
//     -> done_o after 13 cycles; word2 = 64'h0; other words 0.
//     Same with mode 1 -> round_o 6..11; done_o after 7 cycles; word2 = 64'h11.
//  3. start_i held high through a run.
//     -> ignored while ready_o=0; re-accepted in the DONE cycle; next run's round_o starts the following cycle.
//  4. reset_i pulsed when round_o=5.
//     -> next cycle ready_o=1, round_o=0, done_o=0, state_o=0; no done_o afterwards.
//  5. PERM_ABORT_EN: abort_i at round_o=3.
//     -> IDLE next cycle, ready_o=1, no done_o.
//     abort_i and round 11 together -> no done_o.
//  6. Parameters NB_ROUNDS_A=1, NB_ROUNDS_B=12.
//     -> mode 0 single round (round_o=11), done_o after 2 cycles.
//     -> mode 1 round_o 0..11, done_o after 13 cycles.

Source files
------------

// File: rtl/permutation_sequencer.sv
// Iterative ASCON permutation controller driving an external combinational round function.
// Optional feature macro PERM_ABORT_EN adds abort_i to cancel a run in progress.
module permutation_sequencer #(
    parameter int unsigned NB_ROUNDS_A = 12,
    parameter int unsigned NB_ROUNDS_B = 6,
    localparam int unsigned STATE_W = 320,
    localparam int unsigned ROUND_W = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [STATE_W-1:0] state_i,
`ifdef PERM_ABORT_EN
    input  logic               abort_i,
`endif
    output logic               ready_o,
    output logic [ROUND_W-1:0] round_o,
    output logic [STATE_W-1:0] rnd_state_o,
    input  logic [STATE_W-1:0] rnd_state_i,
    output logic               done_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Rounds always end at index 11, so a shorter permutation simply starts later.
    localparam logic [ROUND_W-1:0] FIRST_A    = ROUND_W'(12 - NB_ROUNDS_A);
    localparam logic [ROUND_W-1:0] FIRST_B    = ROUND_W'(12 - NB_ROUNDS_B);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(11);

    logic [1:0]         fsm_q, fsm_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [STATE_W-1:0] sreg_q, sreg_d;
    logic               ready_q;
    logic               done_q;
    logic               abort_c;

`ifdef PERM_ABORT_EN
    assign abort_c = abort_i;
`else
    assign abort_c = 1'b0;
`endif

    // Next-state logic; DONE accepts a new request exactly like IDLE for back-to-back runs.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        sreg_d  = sreg_q;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                fsm_d = ST_IDLE;
                if (start_i) begin
                    fsm_d   = ST_RUN;
                    sreg_d  = state_i;
                    round_d = mode_i ? FIRST_B : FIRST_A;
                end
            end
            ST_RUN: begin
                if (abort_c) begin
                    fsm_d   = ST_IDLE;
                    round_d = '0;
                end else begin
                    sreg_d = rnd_state_i;
                    if (round_q == ROUND_LAST) begin
                        fsm_d   = ST_DONE;
                        round_d = '0;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                    end
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                round_d = '0;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up with fsm_q.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= ST_IDLE;
            round_q <= '0;
            sreg_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            sreg_q  <= sreg_d;
            ready_q <= (fsm_d != ST_RUN);
            done_q  <= (fsm_d == ST_DONE);
        end
    end

    // round_q is zero outside RUN, so it drives the round index directly.
    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign round_o     = round_q;
    assign rnd_state_o = sreg_q;
    assign state_o     = sreg_q;

endmodule

// File: tb/tb_permutation_sequencer.sv
// Bench for permutation_sequencer: offset-based reference model plus directed literal checks.
// Abort scenarios are built only when PERM_ABORT_EN is defined.
module tb_permutation_sequencer;

    localparam int unsigned SW = 320;
    localparam int NA = 12;
    localparam int NB = 6;

    logic          clk = 1'b0;
    logic          rst, start, mode, pc_en;
    logic [SW-1:0] st_in, rnd_in, rnd_out, st_out;
    logic          ready, done;
    logic [3:0]    round;
`ifdef PERM_ABORT_EN
    logic          abort;
`endif

    logic          start2, mode2, ready2, done2;
    logic [SW-1:0] st2, rnd_out2, st_out2;
    logic [3:0]    round2;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    logic [3:0] rq[$];

    always #5 clk = ~clk;

    permutation_sequencer dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .start_i     (start),
        .mode_i      (mode),
        .state_i     (st_in),
`ifdef PERM_ABORT_EN
        .abort_i     (abort),
`endif
        .ready_o     (ready),
        .round_o     (round),
        .rnd_state_o (rnd_out),
        .rnd_state_i (rnd_in),
        .done_o      (done),
        .state_o     (st_out)
    );

    permutation_sequencer #(.NB_ROUNDS_A(1), .NB_ROUNDS_B(12)) dut2 (
        .clock_i     (clk),
        .reset_i     (rst),
        .start_i     (start2),
        .mode_i      (mode2),
        .state_i     (st2),
`ifdef PERM_ABORT_EN
        .abort_i     (1'b0),
`endif
        .ready_o     (ready2),
        .round_o     (round2),
        .rnd_state_o (rnd_out2),
        .rnd_state_i (rnd_out2),
        .done_o      (done2),
        .state_o     (st_out2)
    );

    // Stand-in round function: pc layer only (word2 ^= ASCON round constant) or identity.
    function automatic logic [SW-1:0] rf(input logic [SW-1:0] x, input int r);
        logic [SW-1:0] y;
        logic [7:0]    rc;
        y  = x;
        rc = {4'(15 - r), 4'(r)};
        y[128 +: 8] = y[128 +: 8] ^ rc;
        return y;
    endfunction

    function automatic logic [SW-1:0] fold(input logic [SW-1:0] s, input int first, input int k, input bit pc);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < k; i++) if (pc) r = rf(r, first + i);
        return r;
    endfunction

    always_comb rnd_in = pc_en ? rf(rnd_out, int'(round)) : rnd_out;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: a run is described by its accept cycle; outputs follow from the offset.
    int            cyc = 0;
    int            m_acc = 0;
    int            m_first = 0;
    int            m_n = 0;
    int            m_end = -1;
    bit            m_act = 1'b0;
    bit            m_pc = 1'b0;
    logic [SW-1:0] m_src = '0;
    int            e_off;
    bit            e_run, e_ready, e_done;
    logic [3:0]    e_round;
    logic [SW-1:0] e_state;

    always_comb begin
        e_off   = cyc - m_acc;
        e_run   = m_act && (m_end < 0) && (e_off < m_n);
        e_ready = !e_run;
        e_round = e_run ? 4'(m_first + e_off) : 4'd0;
        e_done  = m_act && (m_end < 0) && (e_off == m_n);
        if (!m_act)          e_state = '0;
        else if (m_end >= 0) e_state = fold(m_src, m_first, m_end, m_pc);
        else                 e_state = fold(m_src, m_first, (e_off < m_n) ? e_off : m_n, m_pc);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_act <= 1'b0;
            m_end <= -1;
        end else if (start && e_ready) begin
            m_act   <= 1'b1;
            m_acc   <= cyc + 1;
            m_first <= mode ? 12 - NB : 12 - NA;
            m_n     <= mode ? NB : NA;
            m_src   <= st_in;
            m_pc    <= pc_en;
            m_end   <= -1;
        end
`ifdef PERM_ABORT_EN
        else if (abort && e_run) begin
            m_end <= e_off;
        end
`endif
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ready_o", SW'(ready), SW'(e_ready));
            chk("round_o", SW'(round), SW'(e_round));
            chk("done_o", SW'(done), SW'(e_done));
            chk("state_o", st_out, e_state);
            chk("rnd_state_o", rnd_out, e_state);
        end
    end

    // Issue one request, hold inputs as junk afterwards, and return the accept-to-done latency.
    task automatic run(input logic m, input logic [SW-1:0] s, output int lat);
        rq.delete();
        start = 1'b1;
        mode  = m;
        st_in = s;
        lat   = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            mode  = ~m;
            st_in = {10{$urandom}};
            lat++;
            if (!done) rq.push_back(round);
        end while (!done && lat < 40);
        chk("run_done_seen", SW'(done), SW'(1));
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        while (round != r && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reached_round", SW'(round), SW'(r));
    endtask

    initial begin
        logic [SW-1:0] s1;
        int lat, d1, d2, ndone;
        rst = 1'b1; start = 1'b0; mode = 1'b0; st_in = '0; pc_en = 1'b0;
        start2 = 1'b0; mode2 = 1'b0; st2 = '0;
`ifdef PERM_ABORT_EN
        abort = 1'b0;
`endif
        s1 = {64'h5, 64'h4, 64'h3, 64'h2, 64'h1};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_ready", SW'(ready), SW'(1));
        chk("rst_round", SW'(round), SW'(0));
        chk("rst_done", SW'(done), SW'(0));
        chk("rst_state", st_out, SW'(0));
        chk("rst_ready2", SW'(ready2), SW'(1));

        // Identity round function, p^12
        run(1'b0, s1, lat);
        chk("t1_latency", SW'(lat), SW'(13));
        chk("t1_nrounds", SW'(rq.size()), SW'(12));
        foreach (rq[i]) chk("t1_round_seq", SW'(rq[i]), SW'(i));
        chk("t1_result", st_out, s1);
        repeat (2) @(negedge clk);

        // pc layer only, zero state
        pc_en = 1'b1;
        run(1'b0, '0, lat);
        chk("t2a_latency", SW'(lat), SW'(13));
        chk("t2a_word2", SW'(st_out[128 +: 64]), SW'(64'h0));
        chk("t2a_other", SW'({st_out[319:192], st_out[127:0]}), SW'(0));
        @(negedge clk);
        run(1'b1, '0, lat);
        chk("t2b_latency", SW'(lat), SW'(7));
        chk("t2b_nrounds", SW'(rq.size()), SW'(6));
        foreach (rq[i]) chk("t2b_round_seq", SW'(rq[i]), SW'(6 + i));
        chk("t2b_word2", SW'(st_out[128 +: 64]), SW'(64'h11));
        chk("t2b_other", SW'({st_out[319:192], st_out[127:0]}), SW'(0));
        repeat (2) @(negedge clk);

        // start held high: re-accepted in DONE with no bubble
        pc_en = 1'b0;
        start = 1'b1; mode = 1'b1; st_in = s1;
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 40 && d2 < 0; c++) begin
            @(negedge clk);
            if (d1 >= 0 && c == d1 + 1) begin
                chk("t3_round_after_done", SW'(round), SW'(6));
                chk("t3_busy_after_done", SW'(ready), SW'(0));
            end
            if (done) begin
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    start = 1'b0;
                end
            end
        end
        chk("t3_first_latency", SW'(d1), SW'(7));
        chk("t3_gap", SW'(d2 - d1), SW'(7));
        repeat (2) @(negedge clk);

        // Reset mid-run drops the run
        start = 1'b1; mode = 1'b0; st_in = s1;
        @(negedge clk);
        start = 1'b0;
        wait_round(4'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_ready", SW'(ready), SW'(1));
        chk("t4_round", SW'(round), SW'(0));
        chk("t4_done", SW'(done), SW'(0));
        chk("t4_state", st_out, SW'(0));
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t4_no_done", SW'(ndone), SW'(0));

`ifdef PERM_ABORT_EN
        // Abort at round 3 keeps the partially permuted state
        pc_en = 1'b1;
        start = 1'b1; mode = 1'b0; st_in = '0;
        @(negedge clk);
        start = 1'b0;
        wait_round(4'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_ready", SW'(ready), SW'(1));
        chk("t5_round", SW'(round), SW'(0));
        chk("t5_done", SW'(done), SW'(0));
        chk("t5_word2", SW'(st_out[128 +: 64]), SW'(64'hc3));
        ndone = 0;
        repeat (16) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_done", SW'(ndone), SW'(0));
        // Abort on the last round beats completion
        start = 1'b1; mode = 1'b0; st_in = '0;
        @(negedge clk);
        start = 1'b0;
        wait_round(4'd11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_last_done", SW'(done), SW'(0));
        chk("t5_last_ready", SW'(ready), SW'(1));
        chk("t5_last_word2", SW'(st_out[128 +: 64]), SW'(64'h4b));
        // Abort in IDLE is ignored
        abort = 1'b1; start = 1'b1; mode = 1'b1; st_in = '0;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("t5_idle_accept", SW'(ready), SW'(0));
        chk("t5_idle_round", SW'(round), SW'(6));
        repeat (8) @(negedge clk);
        pc_en = 1'b0;
`endif

        // NB_ROUNDS_A=1 / NB_ROUNDS_B=12 instance
        start2 = 1'b1; mode2 = 1'b0; st2 = s1;
        @(negedge clk);
        start2 = 1'b0; st2 = '0;
        chk("t6a_round", SW'(round2), SW'(11));
        chk("t6a_busy", SW'(ready2), SW'(0));
        @(negedge clk);
        chk("t6a_done", SW'(done2), SW'(1));
        chk("t6a_state", st_out2, s1);
        @(negedge clk);
        rq.delete();
        start2 = 1'b1; mode2 = 1'b1; st2 = s1;
        lat = 0;
        do begin
            @(negedge clk);
            start2 = 1'b0;
            lat++;
            if (!done2) rq.push_back(round2);
        end while (!done2 && lat < 40);
        chk("t6b_latency", SW'(lat), SW'(13));
        chk("t6b_nrounds", SW'(rq.size()), SW'(12));
        foreach (rq[i]) chk("t6b_round_seq", SW'(rq[i]), SW'(i));
        chk("t6b_state", st_out2, s1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
